bench_report_tx: RTL and testbench



---
 rtl/bench_report_tx.sv | 212 +++++++++++++++++++++
 tb/tb_bench_report_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bench_report_tx.sv
// Serialises a captured benchmark result bundle as one ASCII hex frame over UART 8N1; tx drops one cycle after an accepted report_req.
// No backpressure: requests while busy are dropped and flagged in sticky overrun; REPORT_CHECKSUM_EN appends an XOR checksum field.
module bench_report_tx #(
  parameter int CLKS_PER_BIT = 1085,
  parameter bit HEX_UPPER    = 1'b1
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        report_req,
  input  logic [1:0]  winner_code,
  input  logic [31:0] t_cond0,
  input  logic [31:0] t_cond1,
  input  logic [31:0] t_cond2,
  input  logic [31:0] t_cond3,
  input  logic [31:0] t_total,
  input  logic [31:0] t_runtime,
  input  logic [15:0] ops_per_condition,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

`ifdef REPORT_CHECKSUM_EN
  localparam int N = 66;
`else
  localparam int N = 63;
`endif
  localparam int          LAST_DATA   = 60;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} byte_st_t;
  typedef enum logic [1:0] {B_START, B_DATA, B_STOP} bit_st_t;

  byte_st_t         state_q, state_d;
  bit_st_t          bit_q, bit_d;
  logic [5:0][31:0] snap_w_q, snap_w_d;
  logic [1:0]       snap_win_q, snap_win_d;
  logic [15:0]      snap_ops_q, snap_ops_d;
  logic [7:0]       next_byte_q, next_byte_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [6:0]       idx_q, idx_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [15:0]      baud_q, baud_d;
  logic             tx_q, tx_d;
  logic             ovr_q, ovr_d;
`ifdef REPORT_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  int         bi;
  logic [3:0] enc_nib;
  logic       enc_use;
  logic [7:0] enc_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + {4'h0, v};
    else           return (HEX_UPPER ? 8'h37 : 8'h57) + {4'h0, v};
  endfunction

  // Byte layout: 'R' w, six " XXXXXXXX" words (idx 2..55), " XXXX" ops (56..60), optional " CC", CR LF.
  always_comb begin
    bi       = int'(idx_q);
    enc_byte = 8'h20;
    enc_nib  = 4'h0;
    enc_use  = 1'b0;
    if (bi == 0) enc_byte = 8'h52;
    if (bi == 1) enc_byte = {6'b001100, snap_win_q};
    for (int k = 0; k < 6; k++) begin
      if (bi > 2 + 9*k && bi <= 10 + 9*k) begin
        enc_nib = 4'(snap_w_q[k] >> (4 * (10 + 9*k - bi)));
        enc_use = 1'b1;
      end
    end
    if (bi >= 57 && bi <= 60) begin
      enc_nib = 4'(snap_ops_q >> (4 * (60 - bi)));
      enc_use = 1'b1;
    end
`ifdef REPORT_CHECKSUM_EN
    if (bi == 62) begin
      enc_nib = csum_q[7:4];
      enc_use = 1'b1;
    end
    if (bi == 63) begin
      enc_nib = csum_q[3:0];
      enc_use = 1'b1;
    end
`endif
    if (bi == N - 2) enc_byte = 8'h0D;
    if (bi == N - 1) enc_byte = 8'h0A;
    if (enc_use) enc_byte = hex_char(enc_nib);
  end

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    snap_w_d    = snap_w_q;
    snap_win_d  = snap_win_q;
    snap_ops_d  = snap_ops_q;
    next_byte_d = enc_byte;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    bitcnt_d    = bitcnt_q;
    baud_d      = baud_q;
    tx_d        = tx_q;
    ovr_d       = ovr_q;
`ifdef REPORT_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    busy        = (state_q == S_SEND);
    frame_done  = (state_q == S_DONE);

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (report_req) begin
          snap_w_d   = {t_runtime, t_total, t_cond3, t_cond2, t_cond1, t_cond0};
          snap_win_d = winner_code;
          snap_ops_d = ops_per_condition;
          state_d    = S_SEND;
          bit_d      = B_START;
          baud_d     = BAUD_RELOAD;
          idx_d      = 7'd0;
          tx_d       = 1'b0;
`ifdef REPORT_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end
      end
      S_SEND: begin
        if (report_req) ovr_d = 1'b1;
        if (baud_q != 16'd0) begin
          baud_d = baud_q - 16'd1;
        end else begin
          baud_d = BAUD_RELOAD;
          case (bit_q)
            B_START: begin
              // next_byte_q settled during the start bit, so loading here leaves no inter-byte bubble.
              tx_d     = next_byte_q[0];
              shreg_d  = {1'b0, next_byte_q[7:1]};
              bitcnt_d = 3'd0;
              bit_d    = B_DATA;
`ifdef REPORT_CHECKSUM_EN
              if (idx_q <= 7'(LAST_DATA)) csum_d = csum_q ^ next_byte_q;
`endif
            end
            B_DATA: begin
              if (bitcnt_q == 3'd7) begin
                tx_d  = 1'b1;
                bit_d = B_STOP;
              end else begin
                tx_d     = shreg_q[0];
                shreg_d  = {1'b0, shreg_q[7:1]};
                bitcnt_d = bitcnt_q + 3'd1;
              end
            end
            default: begin
              bit_d = B_START;
              if (idx_q == 7'(N - 1)) begin
                state_d = S_DONE;
              end else begin
                idx_d = idx_q + 7'd1;
                tx_d  = 1'b0;
              end
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_q       <= B_START;
      snap_w_q    <= '0;
      snap_win_q  <= 2'd0;
      snap_ops_q  <= 16'd0;
      next_byte_q <= 8'h00;
      shreg_q     <= 8'h00;
      idx_q       <= 7'd0;
      bitcnt_q    <= 3'd0;
      baud_q      <= 16'd0;
      tx_q        <= 1'b1;
      ovr_q       <= 1'b0;
`ifdef REPORT_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      snap_w_q    <= snap_w_d;
      snap_win_q  <= snap_win_d;
      snap_ops_q  <= snap_ops_d;
      next_byte_q <= next_byte_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      bitcnt_q    <= bitcnt_d;
      baud_q      <= baud_d;
      tx_q        <= tx_d;
      ovr_q       <= ovr_d;
`ifdef REPORT_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_bench_report_tx.sv
// Directed bench for bench_report_tx: string-level frame model, per-cycle waveform compare, UART decoder.
module tb_bench_report_tx;
  localparam int C = 4;
`ifdef REPORT_CHECKSUM_EN
  localparam int NB       = 66;
  localparam int BUSY_LEN = 2640;
`else
  localparam int NB       = 63;
  localparam int BUSY_LEN = 2520;
`endif

  logic        sysclk, rst_n, report_req;
  logic [1:0]  winner_code;
  logic [31:0] t_cond0, t_cond1, t_cond2, t_cond3, t_total, t_runtime;
  logic [15:0] ops_per_condition;
  logic        tx, busy, frame_done, overrun;

  bench_report_tx #(.CLKS_PER_BIT(C), .HEX_UPPER(1'b1)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .report_req(report_req),
    .winner_code(winner_code), .t_cond0(t_cond0), .t_cond1(t_cond1),
    .t_cond2(t_cond2), .t_cond3(t_cond3), .t_total(t_total),
    .t_runtime(t_runtime), .ops_per_condition(ops_per_condition),
    .tx(tx), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 50) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_str(input string nm, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", nm, act, exp);
    end
  endtask

  function automatic string hx(input logic [31:0] v, input int n);
    string hd = "0123456789ABCDEF";
    string s = "";
    for (int i = n - 1; i >= 0; i--) s = {s, $sformatf("%c", hd[int'((v >> (4*i)) & 32'hF)])};
    return s;
  endfunction

  function automatic string build(input logic [1:0] w, input logic [31:0] c0, c1, c2, c3, tt, rt,
                                  input logic [15:0] ops);
    string s;
    s = $sformatf("R%0d", w);
    s = {s, " ", hx(c0, 8), " ", hx(c1, 8), " ", hx(c2, 8), " ", hx(c3, 8)};
    s = {s, " ", hx(tt, 8), " ", hx(rt, 8), " ", hx({16'h0, ops}, 4)};
`ifdef REPORT_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < s.len(); i++) x = x ^ s[i];
      s = {s, " ", hx({24'h0, x}, 2)};
    end
`endif
    s = {s, "\015\012"};
    return s;
  endfunction

  function automatic string cur_frame();
    return build(winner_code, t_cond0, t_cond1, t_cond2, t_cond3, t_total, t_runtime, ops_per_condition);
  endfunction

  // Model: a queue of expected tx levels, one entry per busy cycle.
  logic  mq[$];
  bit    m_done, m_ovr, m_was_busy;
  string m_frame;

  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_done = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      m_was_busy = (mq.size() > 0);
      m_done = 1'b0;
      if (m_was_busy) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1'b1;
      end
      if (report_req) begin
        if (m_was_busy) m_ovr = 1'b1;
        else begin
          m_frame = cur_frame();
          for (int b = 0; b < m_frame.len(); b++) begin
            for (int k = 0; k < C; k++) mq.push_back(1'b0);
            for (int i = 0; i < 8; i++)
              for (int k = 0; k < C; k++) mq.push_back(m_frame[b][i]);
            for (int k = 0; k < C; k++) mq.push_back(1'b1);
          end
        end
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge sysclk) begin
    if (cmp_en) begin
      chk("cyc_tx", {31'h0, tx}, {31'h0, (mq.size() > 0) ? mq[0] : 1'b1});
      chk("cyc_busy", {31'h0, busy}, {31'h0, mq.size() > 0});
      chk("cyc_frame_done", {31'h0, frame_done}, {31'h0, m_done});
      chk("cyc_overrun", {31'h0, overrun}, {31'h0, m_ovr});
    end
  end

  int busy_cnt = 0;
  int done_cnt = 0;
  always @(negedge sysclk) begin
    if (busy === 1'b1) busy_cnt++;
    if (frame_done === 1'b1) done_cnt++;
  end

  // Independent UART receiver sampling mid-bit.
  logic [7:0] rx[$];
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge sysclk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        repeat (C/2) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge sysclk);
          b[i] = tx;
        end
        repeat (C) @(negedge sysclk);
        rx.push_back(b);
      end
    end
  end

  function automatic string rx_str();
    string s = "";
    foreach (rx[i]) s = {s, $sformatf("%c", rx[i])};
    return s;
  endfunction

  task automatic pulse_req();
    report_req = 1'b1;
    @(negedge sysclk);
    report_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (frame_done !== 1'b1) begin
      @(negedge sysclk);
      n++;
      if (n > budget) begin
        chk("frame_done_timeout", 32'(n), 32'(budget));
        return;
      end
    end
  endtask

  string exp2, exp4;
  int    bad;

  initial begin
    rst_n = 1'b0; report_req = 1'b0; winner_code = 2'd0;
    t_cond0 = '0; t_cond1 = '0; t_cond2 = '0; t_cond3 = '0;
    t_total = '0; t_runtime = '0; ops_per_condition = '0;
    repeat (3) @(negedge sysclk);
    cmp_en = 1'b1;
    chk("rst_tx", {31'h0, tx}, 32'd1);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'd0);
    chk("rst_overrun", {31'h0, overrun}, 32'd0);
    rst_n = 1'b1;

    // 1: idle hold
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sysclk);
      if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) bad++;
    end
    chk("idle_hold_bad_cycles", 32'(bad), 32'd0);

    // 2: reference frame
    winner_code = 2'd2; t_cond0 = 32'h00001234; t_cond1 = 32'hDEADBEEF; t_cond2 = 32'h0;
    t_cond3 = 32'hFFFFFFFF; t_total = 32'h0A0B0C0D; t_runtime = 32'h00000100; ops_per_condition = 16'h03E8;
    exp2 = cur_frame();
`ifndef REPORT_CHECKSUM_EN
    chk_str("model_pin", exp2, "R2 00001234 DEADBEEF 00000000 FFFFFFFF 0A0B0C0D 00000100 03E8\015\012");
`endif
    rx.delete(); busy_cnt = 0; done_cnt = 0;
    pulse_req();
    chk("first_start_bit", {31'h0, tx}, 32'd0);
    chk("first_busy", {31'h0, busy}, 32'd1);
    wait_done(4000);
    repeat (3) @(negedge sysclk);
    chk_str("frame2_rx", rx_str(), exp2);
    chk("frame2_len", 32'(rx.size()), 32'(NB));
    chk("busy_len", 32'(busy_cnt), 32'(BUSY_LEN));
    chk("done_pulses", 32'(done_cnt), 32'd1);
`ifdef REPORT_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i <= 60; i++) x = x ^ rx[i];
      chk("cks_space", {24'h0, rx[61]}, 32'h20);
      chk_str("cks_digits", $sformatf("%c%c", rx[62], rx[63]), hx({24'h0, x}, 2));
    end
`endif

    // 3: inputs change right after capture
    rx.delete();
    pulse_req();
    winner_code = 2'd1; t_cond0 = 32'h11111111; t_cond1 = 32'h2222ABCD; t_cond2 = 32'h9;
    t_cond3 = 32'h0; t_total = 32'hCAFEF00D; t_runtime = 32'h7; ops_per_condition = 16'hFACE;
    wait_done(4000);
    repeat (3) @(negedge sysclk);
    chk_str("frame3_captured", rx_str(), exp2);

    // 4: overrun mid-frame, then back-to-back request on frame_done
    exp4 = cur_frame();
    rx.delete();
    pulse_req();
    repeat (10*10*C) @(negedge sysclk);
    pulse_req();
    chk("overrun_set", {31'h0, overrun}, 32'd1);
    wait_done(4000);
    pulse_req();
    chk("b2b_no_gap_tx", {31'h0, tx}, 32'd0);
    chk("b2b_no_gap_busy", {31'h0, busy}, 32'd1);
    wait_done(4000);
    repeat (3) @(negedge sysclk);
    chk_str("frame4_two_frames", rx_str(), {exp4, exp4});
    chk("overrun_sticky", {31'h0, overrun}, 32'd1);

    // 5: reset during byte 30
    pulse_req();
    repeat (30*10*C + 5) @(negedge sysclk);
    @(posedge sysclk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_tx", {31'h0, tx}, 32'd1);
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_overrun", {31'h0, overrun}, 32'd0);
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (60) @(negedge sysclk);
    rx.delete();
    pulse_req();
    wait_done(4000);
    repeat (3) @(negedge sysclk);
    chk_str("frame5_after_reset", rx_str(), exp4);

    repeat (5) @(negedge sysclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
